ysyx_24100006_wb_arb: RTL and testbench
=======================================

Name: ysyx_24100006_wb_arb

Overview:
- Write-port arbiter and scoreboard for the GPR/CSR register-file write port.
- It shares the single write port between two requesters:
  - the in-order pipeline retire path (WBU output);
  - a long-latency execution unit (multi-cycle mul/div), which writes GPRs only.
- It registers the winning write into the register file.
- It keeps a pending-write scoreboard that IDU reads for RAW/WAW hazard stalls.

Parameters:
- XLEN, 32, data width of GPR/CSR writes
- GPR_AW, 4, GPR address width (16 GPRs, RV32E)
- CSR_AW, 12, CSR address width
- PRIO_MODE, 0, conflict policy: 0 = round-robin, 1 = long unit always wins

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- p_valid  in  1  pipeline write request valid
- p_ready  out  1  pipeline request accepted this cycle
- p_gpr_we  in  1  pipeline GPR write enable
- p_gpr_addr  in  GPR_AW  pipeline GPR address
- p_gpr_data  in  XLEN  pipeline GPR data
- p_csr_we  in  1  pipeline CSR write enable
- p_csr_addr  in  CSR_AW  pipeline CSR address
- p_csr_data  in  XLEN  pipeline CSR data
- l_valid  in  1  long-unit result valid
- l_ready  out  1  long-unit result accepted
- l_addr  in  GPR_AW  long-unit destination GPR
- l_data  in  XLEN  long-unit result
- sb_set  in  1  long op dispatched; mark sb_addr pending
- sb_addr  in  GPR_AW  destination of dispatched long op
- rf_gpr_we  out  1  registered GPR write enable
- rf_gpr_addr  out  GPR_AW  registered GPR address
- rf_gpr_data  out  XLEN  registered GPR data
- rf_csr_we  out  1  registered CSR write enable
- rf_csr_addr  out  CSR_AW  registered CSR address
- rf_csr_data  out  XLEN  registered CSR data
- gpr_busy  out  2**GPR_AW  per-GPR pending-long-write bitmap

Behaviour:
- Reset (reset low, asynchronous):
  - all rf_* outputs = 0;
  - gpr_busy = 0;
  - last_grant = P, so the long unit wins the first conflict.
  - Any request in flight is dropped, and the requester must re-present it.
- Grant (combinational from valids and last_grant):
  - only p_valid set: grant P;
  - only l_valid set: grant L;
  - both set, PRIO_MODE=0: grant the requester that is not last_grant;
  - both set, PRIO_MODE=1: grant L;
  - neither set: no grant.
- p_ready = grant==P; l_ready = grant==L.
- Both readies are deasserted when the respective valid is low. They are never both high.
- last_grant updates only on a cycle in which a grant is issued.
- Transfer occurs on valid&ready. The requester holds all fields stable until ready.
- Output stage: the cycle after a transfer, rf_* hold the granted write for exactly one cycle (latency 1). In all other cycles rf_gpr_we = rf_csr_we = 0.
  - P grant: rf_gpr_we = p_gpr_we & (p_gpr_addr != 0); rf_csr_we = p_csr_we.
  - L grant: rf_gpr_we = (l_addr != 0); rf_csr_we = 0.
  - Address and data outputs register the granted fields and hold their value when the enables are 0.
- The x0 rule: a write to x0 completes the handshake but never asserts rf_gpr_we.
- Scoreboard, per bit i:
  - set when sb_set & sb_addr==i & i!=0;
  - cleared on an L transfer with l_addr==i;
  - set and clear on the same cycle for the same i: set wins (a new op was dispatched);
  - bit 0 is constant 0.
  - gpr_busy is registered: visible the cycle after sb_set.
- Ordering:
  - IDU stalls any instruction whose rs/rd hits gpr_busy, so P never writes a register with a pending L write. The arbiter does not re-check this.
  - The long unit returns results in dispatch order.
- A P request with p_gpr_we=0 and p_csr_we=0 (store, branch) still consumes a grant slot and produces no write.

Decomposition:
- Shared package ysyx_24100006_pkg holds:
  - grant encoding constants (GNT_NONE, GNT_P, GNT_L);
  - PRIO_MODE values;
  - XLEN, GPR_AW and CSR_AW defaults.
- One natural sub-module: ysyx_24100006_wb_scoreboard (busy bitmap, set/clear logic), instantiated once. Arbitration and the output register stay in the top.

Test Plan:
- Only p_valid=1, gpr_we=1, addr=5, data=0xDEADBEEF -> p_ready=1 same cycle; next cycle rf_gpr_we=1, addr=5, data=0xDEADBEEF; cycle after that, we=0.
- After reset, p_valid=l_valid=1 held for 4 cycles (PRIO_MODE=0) -> grants L,P,L,P; rf writes alternate l_data/p_data with no dropped or duplicated beats.
- PRIO_MODE=1, both valid for 3 cycles then l_valid=0 -> L,L,L then P; p_ready stays 0 throughout the first three cycles.
- sb_set addr=7, later L transfer l_addr=7 -> gpr_busy[7]=1 from the cycle after sb_set until the cycle after the L transfer; sb_set addr=7 coinciding with that transfer -> gpr_busy[7] stays 1.
- P write to x0 with gpr_we=1, plus csr_we=1 to 0x305 with data 0x80000000 -> p_ready=1; next cycle rf_gpr_we=0, rf_csr_we=1, rf_csr_addr=0x305, rf_csr_data=0x80000000. sb_set addr=0 -> gpr_busy[0] stays 0.
- Assert reset low asynchronously mid-transfer, with rf_gpr_we=1 and gpr_busy=0x0080 -> all outputs 0 immediately; after release, the first conflict grants L.

Source files
------------

// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Includes the grant encoding, the priority policy values and the default widths.
package ysyx_24100006_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_GPR_AW = 4;
    localparam int DEF_CSR_AW = 12;

    localparam int PRIO_RR   = 0;
    localparam int PRIO_LONG = 1;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_P    = 2'd1;
    localparam gnt_t GNT_L    = 2'd2;

endpackage

// File: rtl/ysyx_24100006_wb_scoreboard.sv
// Pending long-unit write bitmap read by IDU for hazard stalls.
// When a register is set and cleared in the same cycle, the set wins, because a newer op was dispatched.
module ysyx_24100006_wb_scoreboard
    import ysyx_24100006_pkg::*;
#(
    parameter int GPR_AW = DEF_GPR_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sb_set,
    input  logic [GPR_AW-1:0]        sb_addr,
    input  logic                     clr,
    input  logic [GPR_AW-1:0]        clr_addr,
    output logic [(2**GPR_AW)-1:0]   gpr_busy
);

    localparam int NREG = 2**GPR_AW;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sb_set) set_mask[sb_addr] = 1'b1;
        if (clr)    clr_mask[clr_addr] = 1'b1;
        busy_next    = (gpr_busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) gpr_busy <= '0;
        else        gpr_busy <= busy_next;
    end

endmodule

// File: rtl/ysyx_24100006_wb_arb.sv
// Arbitrates the single GPR/CSR write port between the retire path (P) and the long unit (L).
// The winning write is registered one cycle after its handshake.
module ysyx_24100006_wb_arb
    import ysyx_24100006_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int GPR_AW    = DEF_GPR_AW,
    parameter int CSR_AW    = DEF_CSR_AW,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_valid,
    output logic                     p_ready,
    input  logic                     p_gpr_we,
    input  logic [GPR_AW-1:0]        p_gpr_addr,
    input  logic [XLEN-1:0]          p_gpr_data,
    input  logic                     p_csr_we,
    input  logic [CSR_AW-1:0]        p_csr_addr,
    input  logic [XLEN-1:0]          p_csr_data,
    input  logic                     l_valid,
    output logic                     l_ready,
    input  logic [GPR_AW-1:0]        l_addr,
    input  logic [XLEN-1:0]          l_data,
    input  logic                     sb_set,
    input  logic [GPR_AW-1:0]        sb_addr,
    output logic                     rf_gpr_we,
    output logic [GPR_AW-1:0]        rf_gpr_addr,
    output logic [XLEN-1:0]          rf_gpr_data,
    output logic                     rf_csr_we,
    output logic [CSR_AW-1:0]        rf_csr_addr,
    output logic [XLEN-1:0]          rf_csr_data,
    output logic [(2**GPR_AW)-1:0]   gpr_busy
);

    gnt_t grant;
    gnt_t last_grant;

    logic              gpr_we_p1;
    logic [GPR_AW-1:0] gpr_addr_p1;
    logic [XLEN-1:0]   gpr_data_p1;
    logic              csr_we_p1;
    logic [CSR_AW-1:0] csr_addr_p1;
    logic [XLEN-1:0]   csr_data_p1;

    // No grant while reset is held, so that a request in flight is dropped and not accepted.
    always_comb begin
        grant = GNT_NONE;
        if (reset) begin
            if (p_valid && l_valid)
                grant = (PRIO_MODE == PRIO_LONG || last_grant == GNT_P) ? GNT_L : GNT_P;
            else if (p_valid)
                grant = GNT_P;
            else if (l_valid)
                grant = GNT_L;
        end
    end

    assign p_ready = (grant == GNT_P);
    assign l_ready = (grant == GNT_L);

    // Stage p1: registered write, with the write enables asserted for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= GNT_P;
            gpr_we_p1   <= 1'b0;
            gpr_addr_p1 <= '0;
            gpr_data_p1 <= '0;
            csr_we_p1   <= 1'b0;
            csr_addr_p1 <= '0;
            csr_data_p1 <= '0;
        end else begin
            gpr_we_p1 <= 1'b0;
            csr_we_p1 <= 1'b0;
            if (grant != GNT_NONE) last_grant <= grant;
            if (grant == GNT_P) begin
                gpr_we_p1   <= p_gpr_we & (p_gpr_addr != '0);
                gpr_addr_p1 <= p_gpr_addr;
                gpr_data_p1 <= p_gpr_data;
                csr_we_p1   <= p_csr_we;
                if (p_csr_we) begin
                    csr_addr_p1 <= p_csr_addr;
                    csr_data_p1 <= p_csr_data;
                end
            end else if (grant == GNT_L) begin
                gpr_we_p1   <= (l_addr != '0);
                gpr_addr_p1 <= l_addr;
                gpr_data_p1 <= l_data;
            end
        end
    end

    assign rf_gpr_we   = gpr_we_p1;
    assign rf_gpr_addr = gpr_addr_p1;
    assign rf_gpr_data = gpr_data_p1;
    assign rf_csr_we   = csr_we_p1;
    assign rf_csr_addr = csr_addr_p1;
    assign rf_csr_data = csr_data_p1;

    ysyx_24100006_wb_scoreboard #(
        .GPR_AW (GPR_AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .clr      (grant == GNT_L),
        .clr_addr (l_addr),
        .gpr_busy (gpr_busy)
    );

endmodule

// File: tb/tb_ysyx_24100006_wb_arb.sv
// Scoreboard bench for the write-port arbiter: one round-robin instance and one long-priority instance.
module tb_ysyx_24100006_wb_arb;

    logic        clk, reset;
    logic        p_valid, p_valid1, p_gpr_we, p_csr_we, l_valid, l_valid1, sb_set;
    logic [3:0]  p_gpr_addr, l_addr, sb_addr;
    logic [31:0] p_gpr_data, p_csr_data, l_data;
    logic [11:0] p_csr_addr;

    logic        p_ready, l_ready, rf_gpr_we, rf_csr_we;
    logic [3:0]  rf_gpr_addr;
    logic [31:0] rf_gpr_data, rf_csr_data;
    logic [11:0] rf_csr_addr;
    logic [15:0] gpr_busy;

    logic        p_ready1, l_ready1, rf1_gpr_we, rf1_csr_we;
    logic [3:0]  rf1_gpr_addr;
    logic [31:0] rf1_gpr_data, rf1_csr_data;
    logic [11:0] rf1_csr_addr;
    logic [15:0] gpr_busy1;

    typedef struct {
        int          due;
        logic        gwe;
        logic [3:0]  ga;
        logic [31:0] gd;
        logic        cwe;
        logic [11:0] ca;
        logic [31:0] cd;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ysyx_24100006_wb_arb #(.PRIO_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_ready(p_ready),
        .p_gpr_we(p_gpr_we), .p_gpr_addr(p_gpr_addr), .p_gpr_data(p_gpr_data),
        .p_csr_we(p_csr_we), .p_csr_addr(p_csr_addr), .p_csr_data(p_csr_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rf_gpr_we(rf_gpr_we), .rf_gpr_addr(rf_gpr_addr), .rf_gpr_data(rf_gpr_data),
        .rf_csr_we(rf_csr_we), .rf_csr_addr(rf_csr_addr), .rf_csr_data(rf_csr_data),
        .gpr_busy(gpr_busy)
    );

    ysyx_24100006_wb_arb #(.PRIO_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .p_valid(p_valid1), .p_ready(p_ready1),
        .p_gpr_we(p_gpr_we), .p_gpr_addr(p_gpr_addr), .p_gpr_data(p_gpr_data),
        .p_csr_we(p_csr_we), .p_csr_addr(p_csr_addr), .p_csr_data(p_csr_data),
        .l_valid(l_valid1), .l_ready(l_ready1), .l_addr(l_addr), .l_data(l_data),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rf_gpr_we(rf1_gpr_we), .rf_gpr_addr(rf1_gpr_addr), .rf_gpr_data(rf1_gpr_data),
        .rf_csr_we(rf1_csr_we), .rf_csr_addr(rf1_csr_addr), .rf_csr_data(rf1_csr_data),
        .gpr_busy(gpr_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_p();
        exp_t e;
        e.due = cyc + 1;
        e.gwe = p_gpr_we && (p_gpr_addr != 4'd0);
        e.ga  = p_gpr_addr;
        e.gd  = p_gpr_data;
        e.cwe = p_csr_we;
        e.ca  = p_csr_addr;
        e.cd  = p_csr_data;
        q.push_back(e);
    endtask

    task automatic push_l();
        exp_t e;
        e.due = cyc + 1;
        e.gwe = (l_addr != 4'd0);
        e.ga  = l_addr;
        e.gd  = l_data;
        e.cwe = 1'b0;
        e.ca  = 12'd0;
        e.cd  = 32'd0;
        q.push_back(e);
    endtask

    // Every cycle out of reset: either the queued write appears now, or nothing is written.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    checks++;
                    if (rf_gpr_we !== e.gwe || rf_csr_we !== e.cwe ||
                        (e.gwe && (rf_gpr_addr !== e.ga || rf_gpr_data !== e.gd)) ||
                        (e.cwe && (rf_csr_addr !== e.ca || rf_csr_data !== e.cd))) begin
                        errors++;
                        $display("FAIL rf_write cyc=%0d got gwe=%b ga=%0d gd=%h cwe=%b ca=%h cd=%h want gwe=%b ga=%0d gd=%h cwe=%b ca=%h cd=%h",
                                 cyc, rf_gpr_we, rf_gpr_addr, rf_gpr_data, rf_csr_we, rf_csr_addr, rf_csr_data,
                                 e.gwe, e.ga, e.gd, e.cwe, e.ca, e.cd);
                    end
                end else begin
                    checks++;
                    if (rf_gpr_we !== 1'b0 || rf_csr_we !== 1'b0) begin
                        errors++;
                        $display("FAIL rf_idle cyc=%0d got gwe=%b cwe=%b want 0 0", cyc, rf_gpr_we, rf_csr_we);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        p_valid = 1'b1; l_valid = 1'b1;
        #12;
        checks++;
        if ({rf_gpr_we, rf_gpr_addr, rf_gpr_data} !== 37'd0) begin
            errors++; $display("FAIL reset_rf_gpr got %b/%h/%h want 0", rf_gpr_we, rf_gpr_addr, rf_gpr_data);
        end
        checks++;
        if ({rf_csr_we, rf_csr_addr, rf_csr_data} !== 45'd0) begin
            errors++; $display("FAIL reset_rf_csr got %b/%h/%h want 0", rf_csr_we, rf_csr_addr, rf_csr_data);
        end
        checks++;
        if (gpr_busy !== 16'h0) begin
            errors++; $display("FAIL reset_busy got %h want 0", gpr_busy);
        end
        checks++;
        if (p_ready !== 1'b0 || l_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got p=%b l=%b want 0 0", p_ready, l_ready);
        end
        p_valid = 1'b0; l_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_l;
        tick();
        p_gpr_we = 1'b1; p_gpr_addr = 4'd3; p_gpr_data = 32'h1000; p_csr_we = 1'b0;
        l_addr = 4'd9; l_data = 32'h2000;
        p_valid = 1'b1; l_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_l = (k % 2 == 0);
            checks++;
            if (l_ready !== exp_l || p_ready !== !exp_l) begin
                errors++; $display("FAIL rr_grant k=%0d got p=%b l=%b want l=%b", k, p_ready, l_ready, exp_l);
            end
            if (exp_l) push_l(); else push_p();
            tick();
            if (exp_l) l_data = l_data + 1; else p_gpr_data = p_gpr_data + 1;
        end
        p_valid = 1'b0; l_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_single_p();
        tick();
        p_valid = 1'b1; p_gpr_we = 1'b1; p_gpr_addr = 4'd5; p_gpr_data = 32'hDEADBEEF; p_csr_we = 1'b0;
        #1;
        checks++;
        if (p_ready !== 1'b1 || l_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got p=%b l=%b want 1 0", p_ready, l_ready);
        end
        push_p();
        tick();
        p_valid = 1'b0;
        checks++;
        if (rf_gpr_we !== 1'b1 || rf_gpr_addr !== 4'd5 || rf_gpr_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rf got %b/%0d/%h want 1/5/deadbeef", rf_gpr_we, rf_gpr_addr, rf_gpr_data);
        end
        tick();
        checks++;
        if (rf_gpr_we !== 1'b0) begin
            errors++; $display("FAIL single_we_drop got %b want 0", rf_gpr_we);
        end
    endtask

    task automatic test_prio_long();
        tick();
        p_gpr_we = 1'b1; p_gpr_addr = 4'd4; p_gpr_data = 32'hAAAA0000; p_csr_we = 1'b0;
        l_addr = 4'd10; l_data = 32'hBBBB0000;
        p_valid1 = 1'b1; l_valid1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (l_ready1 !== 1'b1 || p_ready1 !== 1'b0) begin
                errors++; $display("FAIL prio_grant k=%0d got p=%b l=%b want 0 1", k, p_ready1, l_ready1);
            end
            tick();
            checks++;
            if (rf1_gpr_we !== 1'b1 || rf1_gpr_addr !== 4'd10 || rf1_gpr_data !== l_data) begin
                errors++; $display("FAIL prio_rf_l k=%0d got %b/%0d/%h want 1/10/%h", k, rf1_gpr_we, rf1_gpr_addr, rf1_gpr_data, l_data);
            end
            l_data = l_data + 1;
        end
        l_valid1 = 1'b0;
        #1;
        checks++;
        if (p_ready1 !== 1'b1 || l_ready1 !== 1'b0) begin
            errors++; $display("FAIL prio_p_after got p=%b l=%b want 1 0", p_ready1, l_ready1);
        end
        tick();
        p_valid1 = 1'b0;
        checks++;
        if (rf1_gpr_we !== 1'b1 || rf1_gpr_addr !== 4'd4 || rf1_gpr_data !== 32'hAAAA0000) begin
            errors++; $display("FAIL prio_rf_p got %b/%0d/%h want 1/4/aaaa0000", rf1_gpr_we, rf1_gpr_addr, rf1_gpr_data);
        end
        tick();
        checks++;
        if (rf1_gpr_we !== 1'b0) begin
            errors++; $display("FAIL prio_idle got %b want 0", rf1_gpr_we);
        end
    endtask

    task automatic test_scoreboard();
        tick();
        sb_set = 1'b1; sb_addr = 4'd7;
        #1;
        checks++;
        if (gpr_busy[7] !== 1'b0) begin
            errors++; $display("FAIL sb_early got %b want 0", gpr_busy[7]);
        end
        tick();
        sb_set = 1'b0;
        checks++;
        if (gpr_busy !== 16'h0080) begin
            errors++; $display("FAIL sb_set got %h want 0080", gpr_busy);
        end
        tick();
        checks++;
        if (gpr_busy[7] !== 1'b1) begin
            errors++; $display("FAIL sb_hold got %b want 1", gpr_busy[7]);
        end
        l_valid = 1'b1; l_addr = 4'd7; l_data = 32'h77;
        #1;
        checks++;
        if (l_ready !== 1'b1) begin
            errors++; $display("FAIL sb_l_ready got %b want 1", l_ready);
        end
        push_l();
        tick();
        l_valid = 1'b0;
        checks++;
        if (gpr_busy[7] !== 1'b0) begin
            errors++; $display("FAIL sb_clear got %b want 0", gpr_busy[7]);
        end
        sb_set = 1'b1; sb_addr = 4'd7;
        tick();
        sb_set = 1'b0;
        l_valid = 1'b1; l_data = 32'h78; sb_set = 1'b1;
        #1;
        push_l();
        tick();
        l_valid = 1'b0; sb_set = 1'b0;
        checks++;
        if (gpr_busy[7] !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins got %b want 1", gpr_busy[7]);
        end
        l_valid = 1'b1; l_data = 32'h79;
        #1;
        push_l();
        tick();
        l_valid = 1'b0;
        checks++;
        if (gpr_busy !== 16'h0) begin
            errors++; $display("FAIL sb_drain got %h want 0", gpr_busy);
        end
    endtask

    task automatic test_x0_csr();
        tick();
        p_valid = 1'b1; p_gpr_we = 1'b1; p_gpr_addr = 4'd0; p_gpr_data = 32'h1234;
        p_csr_we = 1'b1; p_csr_addr = 12'h305; p_csr_data = 32'h80000000;
        sb_set = 1'b1; sb_addr = 4'd0;
        #1;
        checks++;
        if (p_ready !== 1'b1) begin
            errors++; $display("FAIL x0_ready got %b want 1", p_ready);
        end
        push_p();
        tick();
        p_valid = 1'b0; p_csr_we = 1'b0; sb_set = 1'b0;
        checks++;
        if (rf_gpr_we !== 1'b0 || rf_csr_we !== 1'b1 || rf_csr_addr !== 12'h305 || rf_csr_data !== 32'h80000000) begin
            errors++; $display("FAIL x0_csr got gwe=%b cwe=%b ca=%h cd=%h want 0 1 305 80000000", rf_gpr_we, rf_csr_we, rf_csr_addr, rf_csr_data);
        end
        checks++;
        if (gpr_busy !== 16'h0) begin
            errors++; $display("FAIL x0_busy got %h want 0", gpr_busy);
        end
        tick();
    endtask

    task automatic test_no_write_p();
        tick();
        p_valid = 1'b1; p_gpr_we = 1'b0; p_csr_we = 1'b0; p_gpr_addr = 4'd6;
        #1;
        checks++;
        if (p_ready !== 1'b1) begin
            errors++; $display("FAIL nowrite_ready got %b want 1", p_ready);
        end
        push_p();
        tick();
        p_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        tick();
        sb_set = 1'b1; sb_addr = 4'd7;
        p_valid = 1'b1; p_gpr_we = 1'b1; p_gpr_addr = 4'd5; p_gpr_data = 32'hCAFE0001; p_csr_we = 1'b0;
        #1;
        push_p();
        tick();
        sb_set = 1'b0;
        p_gpr_data = 32'hCAFE0002;
        checks++;
        if (rf_gpr_we !== 1'b1 || gpr_busy !== 16'h0080) begin
            errors++; $display("FAIL arst_pre got we=%b busy=%h want 1 0080", rf_gpr_we, gpr_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({rf_gpr_we, rf_gpr_addr, rf_gpr_data, rf_csr_we, rf_csr_addr, rf_csr_data} !== 82'd0) begin
            errors++; $display("FAIL arst_rf got gwe=%b ga=%h gd=%h cwe=%b ca=%h cd=%h want 0",
                               rf_gpr_we, rf_gpr_addr, rf_gpr_data, rf_csr_we, rf_csr_addr, rf_csr_data);
        end
        checks++;
        if (gpr_busy !== 16'h0 || p_ready !== 1'b0) begin
            errors++; $display("FAIL arst_busy_ready got busy=%h p_ready=%b want 0 0", gpr_busy, p_ready);
        end
        p_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        p_valid = 1'b1; p_gpr_addr = 4'd2; p_gpr_data = 32'h22;
        l_valid = 1'b1; l_addr = 4'd11; l_data = 32'h11;
        #1;
        checks++;
        if (l_ready !== 1'b1 || p_ready !== 1'b0) begin
            errors++; $display("FAIL arst_first_conflict got p=%b l=%b want 0 1", p_ready, l_ready);
        end
        push_l();
        tick();
        #1;
        checks++;
        if (p_ready !== 1'b1 || l_ready !== 1'b0) begin
            errors++; $display("FAIL arst_second_conflict got p=%b l=%b want 1 0", p_ready, l_ready);
        end
        push_p();
        tick();
        p_valid = 1'b0; l_valid = 1'b0;
        tick();
    endtask

    initial begin
        p_valid = 1'b0; p_valid1 = 1'b0; l_valid = 1'b0; l_valid1 = 1'b0;
        p_gpr_we = 1'b0; p_gpr_addr = 4'd0; p_gpr_data = 32'd0;
        p_csr_we = 1'b0; p_csr_addr = 12'd0; p_csr_data = 32'd0;
        l_addr = 4'd0; l_data = 32'd0; sb_set = 1'b0; sb_addr = 4'd0;
        test_reset();
        test_round_robin();
        test_single_p();
        test_prio_long();
        test_scoreboard();
        test_x0_csr();
        test_no_write_p();
        test_async_reset();
        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL queue_drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
